// File: rtl/dmem_pkg.sv
// Shared types and default widths for the data-memory responder and the CPU.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } dmem_state_t;

  localparam int DMEM_MAX_WAIT    = 15;
  localparam int DMEM_ADDR_W      = 8;
  localparam int DMEM_DATA_W      = 8;
  localparam int DMEM_DEPTH       = 128;
  localparam int DMEM_WAIT_CYCLES = 2;

endpackage

// File: rtl/dmem_responder_if.sv
// Four-phase req/ack load/store bus between the CPU memory stage and dmem_responder.
interface dmem_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              err;
  logic              busy;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack, err, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack, err, busy
  );
endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, DEPTH x DATA_W, with write enable and registered read.
module dmem_array #(
  parameter int DEPTH  = 128,
  parameter int DATA_W = 8,
  parameter int IDX_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  // Storage is never reset; only the read register is, so rdata starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: req/ack FSM, wait-state counter, request latch, range check.
// Optional out-of-range detection is enabled by defining DMEM_RANGE_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = DMEM_ADDR_W,
  parameter int DATA_W      = DMEM_DATA_W,
  parameter int DEPTH       = DMEM_DEPTH,
  parameter int WAIT_CYCLES = DMEM_WAIT_CYCLES
) (
  input logic             clk,
  input logic             rst_n,
  dmem_responder_if.slave bus
);

  localparam int               IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]       WAIT_LOAD = 4'(WAIT_CYCLES);
  localparam logic [ADDR_W:0]  DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  dmem_state_t       state, next_state;
  logic [3:0]        cnt;
  logic              we_q;
  logic              ok_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              acc_we;
  logic              acc_ok;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              enter_ack;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_dout;
  logic              take_req;

  assign take_req = (state == IDLE) && bus.req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.req) next_state = (WAIT_CYCLES == 0) ? ACK : WAIT;
      WAIT:    if (cnt <= 4'd1) next_state = ACK;
      ACK:     next_state = bus.req ? RELEASE : IDLE;
      RELEASE: if (!bus.req) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               cnt <= '0;
    else if (take_req)        cnt <= WAIT_LOAD;
    else if (state == WAIT)   cnt <= cnt - 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      ok_q    <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (take_req) begin
      we_q    <= bus.we;
      ok_q    <= acc_ok;
      addr_q  <= bus.addr;
      wdata_q <= bus.wdata;
    end
  end

  // With zero wait states the array is accessed on the same edge that latches
  // the request, so the access fields bypass the latch while still in IDLE.
  always_comb begin
    acc_we    = (state == IDLE) ? bus.we    : we_q;
    acc_addr  = (state == IDLE) ? bus.addr  : addr_q;
    acc_wdata = (state == IDLE) ? bus.wdata : wdata_q;
`ifdef DMEM_RANGE_CHECK_EN
    acc_ok    = ({1'b0, acc_addr} < DEPTH_LIM);
`else
    acc_ok    = 1'b1;
`endif
  end

  assign enter_ack = (next_state == ACK) && (state != ACK);
  assign mem_we    = enter_ack &&  acc_we && acc_ok;
  assign mem_re    = enter_ack && !acc_we && acc_ok;

  dmem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .re    (mem_re),
    .idx   (acc_addr[IDX_W-1:0]),
    .wdata (acc_wdata),
    .rdata (mem_dout)
  );

  always_comb begin
    bus.ack   = (state == ACK);
    bus.busy  = (state != IDLE);
`ifdef DMEM_RANGE_CHECK_EN
    bus.err   = (state == ACK) && !ok_q;
`else
    bus.err   = 1'b0;
`endif
    bus.rdata = ((state == ACK) && (we_q || !ok_q)) ? '0 : mem_dout;
  end

  logic unused_ok;
  assign unused_ok = ^DEPTH_LIM;

endmodule
